// File: rtl/mem_access_if.sv
// Data-memory port between the MEM-stage load/store unit (master) and data memory (slave).
// The request fields are held stable from request until acknowledge.
interface mem_access_if #(
  parameter int DATA_WIDTH = 32
);
  logic                      req;
  logic                      we;
  logic [DATA_WIDTH-1:0]     addr;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      ack;
  logic [DATA_WIDTH-1:0]     rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output ack, rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: byte/half/word accesses on a ready/ack memory port,
// pipeline hold while an access is outstanding, extended load result for MEM/WB.
module mem_access_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 255,
  parameter int CTRL_RD_BIT = 0,
  parameter int CTRL_WR_BIT = 1
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_ctrl,
  input  logic [DATA_WIDTH-1:0] i_alu,
  input  logic [DATA_WIDTH-1:0] i_data2,
  input  logic [DATA_WIDTH-1:0] i_instr,
  output logic                  o_stall,
  output logic [DATA_WIDTH-1:0] o_load_data,
  output logic                  o_misaligned,
  output logic                  o_bus_err,
  mem_access_if.master          mem
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {4{d[7:0]}};
      3'b001:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] store_wstrb(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  return 4'b0001 << off;
      3'b001:  return 4'b0011 << off;
      3'b010:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b010:  return rdata;
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] load_q, load_d;
  logic        bus_err_q, bus_err_d;

  logic        rd, wr, mem_op, f3_ok, mis, fault, go;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic        unused_inputs;

  assign rd     = i_ctrl[CTRL_RD_BIT];
  assign wr     = i_ctrl[CTRL_WR_BIT];
  assign mem_op = rd | wr;
  assign f3     = i_instr[14:12];
  assign off    = i_alu[1:0];
  assign unused_inputs = ^{i_ctrl, i_instr};

  // Decode of the op presented in IDLE; write wins when both control bits are set
  always_comb begin
    f3_ok = 1'b0;
    mis   = 1'b0;
    case (f3)
      3'b000:         f3_ok = 1'b1;
      3'b001:         begin f3_ok = 1'b1; mis = off[0]; end
      3'b010:         begin f3_ok = 1'b1; mis = (off != 2'b00); end
      3'b100, 3'b101: begin f3_ok = !wr; mis = f3[0] & off[0]; end
      default:        f3_ok = 1'b0;
    endcase
  end

  assign fault = mem_op && (!f3_ok || mis);
  assign go    = (state_q == IDLE) && mem_op && !fault;

  assign o_stall      = !i_rst && (go || (state_q == ACCESS));
  assign o_misaligned = !i_rst && (state_q == IDLE) && fault;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    f3_d      = f3_q;
    off_d     = off_q;
    load_d    = load_q;
    bus_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = ACCESS;
          cnt_d   = 8'd0;
          req_d   = 1'b1;
          we_d    = wr;
          addr_d  = {i_alu[31:2], 2'b00};
          wdata_d = store_wdata(f3, i_data2);
          wstrb_d = wr ? store_wstrb(f3, off) : 4'b0000;
          f3_d    = f3;
          off_d   = off;
        end else if (fault) begin
          load_d = 32'd0;
        end
      end
      ACCESS: begin
        // Ack in the final counted cycle still completes normally
        if (mem.ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          load_d  = we_q ? 32'd0 : load_extend(f3_q, off_q, mem.rdata);
        end else if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          req_d     = 1'b0;
          load_d    = 32'd0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      load_q    <= 32'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      load_q    <= load_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign mem.req     = req_q;
  assign mem.we      = we_q;
  assign mem.addr    = addr_q;
  assign mem.wdata   = wdata_q;
  assign mem.wstrb   = wstrb_q;
  assign o_load_data = load_q;
  assign o_bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected DONE results are queued when an op
// is driven and compared when the request drops.
module tb_mem_access_unit;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_ctrl, i_alu, i_data2, i_instr;
  logic        o_stall, o_misaligned, o_bus_err;
  logic [31:0] o_load_data;

  mem_access_if #(.DATA_WIDTH(32)) mem_if ();

  mem_access_unit #(.DATA_WIDTH(32), .TIMEOUT(TMO), .CTRL_RD_BIT(0), .CTRL_WR_BIT(1)) dut (
    .clk(clk), .i_rst(i_rst), .i_ctrl(i_ctrl), .i_alu(i_alu), .i_data2(i_data2),
    .i_instr(i_instr), .o_stall(o_stall), .o_load_data(o_load_data),
    .o_misaligned(o_misaligned), .o_bus_err(o_bus_err), .mem(mem_if)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] load; logic berr; } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Result monitor: DONE is the cycle after the request drops (outside reset)
  logic prev_req = 1'b0, prev_rst = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (prev_req && !mem_if.req && !prev_rst) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("sb_load", o_load_data, e.load);
        chk("sb_berr", {31'd0, o_bus_err}, {31'd0, e.berr});
      end
    end
    prev_req = mem_if.req;
    prev_rst = i_rst;
  end

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] r);
    logic [7:0] b; logic [15:0] h;
    case (off)
      2'd0: b = r[7:0];
      2'd1: b = r[15:8];
      2'd2: b = r[23:16];
      default: b = r[31:24];
    endcase
    h = off[1] ? r[31:16] : r[15:0];
    case (f3)
      3'd0: return {{24{b[7]}}, b};
      3'd1: return {{16{h[15]}}, h};
      3'd4: return {24'd0, b};
      3'd5: return {16'd0, h};
      default: return r;
    endcase
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] off);
    if (f3 == 3'd2) return 4'b1111;
    if (f3 == 3'd1) return off[1] ? 4'b1100 : 4'b0011;
    case (off)
      2'd0: return 4'b0001;
      2'd1: return 4'b0010;
      2'd2: return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (f3 == 3'd1) return {d[15:0], d[15:0]};
    return d;
  endfunction

  task automatic drive(input logic wr, input logic rd, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data);
    i_ctrl  = {30'd0, wr, rd};
    i_alu   = addr;
    i_data2 = data;
    i_instr = {17'd0, f3, 12'h0b3};
  endtask

  // ack_after = 0 means no ack (timeout expected)
  task automatic run_op(input string tag, input logic wr, input logic rd, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data, input int ack_after,
                        input logic [31:0] rdata, input logic [31:0] exp_wdata,
                        input logic [3:0] exp_wstrb, input logic [31:0] exp_load,
                        input logic exp_berr);
    exp_t e;
    int cyc, stalls, reqs, n_exp;
    bit done;
    n_exp = (ack_after == 0) ? TMO : ack_after;
    @(posedge clk); #1;
    drive(wr, rd, f3, addr, data);
    e.load = exp_load; e.berr = exp_berr;
    sb.push_back(e);
    @(negedge clk);
    stalls = o_stall ? 1 : 0;
    reqs = 0;
    chk({tag, "_idle_misal"}, {31'd0, o_misaligned}, 32'd0);
    cyc = 0; done = 0;
    while (!done && cyc < TMO + 2) begin
      @(posedge clk); #1;
      cyc++;
      mem_if.ack   = (cyc == ack_after);
      mem_if.rdata = (cyc == ack_after) ? rdata : $urandom;
      @(negedge clk);
      if (o_stall) stalls++;
      if (mem_if.req) reqs++;
      chk({tag, "_acc_berr"}, {31'd0, o_bus_err}, 32'd0);
      if (cyc == 1) begin
        chk({tag, "_addr"}, mem_if.addr, {addr[31:2], 2'b00});
        chk({tag, "_we"}, {31'd0, mem_if.we}, {31'd0, wr});
        if (wr) begin
          chk({tag, "_wdata"}, mem_if.wdata, exp_wdata);
          chk({tag, "_wstrb"}, {28'd0, mem_if.wstrb}, {28'd0, exp_wstrb});
        end
      end
      if (cyc == n_exp) done = 1;
    end
    @(posedge clk); #1;
    mem_if.ack = 1'b0;
    i_ctrl = 32'd0;
    @(negedge clk);
    chk({tag, "_done_stall"}, {31'd0, o_stall}, 32'd0);
    chk({tag, "_done_req"}, {31'd0, mem_if.req}, 32'd0);
    chk({tag, "_stall_cycles"}, stalls, n_exp + 1);
    chk({tag, "_req_cycles"}, reqs, n_exp);
  endtask

  task automatic run_fault(input string tag, input logic wr, input logic rd,
                           input logic [2:0] f3, input logic [31:0] addr);
    @(posedge clk); #1;
    drive(wr, rd, f3, addr, 32'h1234_5678);
    @(negedge clk);
    chk({tag, "_misal"}, {31'd0, o_misaligned}, 32'd1);
    chk({tag, "_stall"}, {31'd0, o_stall}, 32'd0);
    chk({tag, "_req"}, {31'd0, mem_if.req}, 32'd0);
    @(posedge clk); #1;
    i_ctrl = 32'd0;
    @(negedge clk);
    chk({tag, "_pulse_end"}, {31'd0, o_misaligned}, 32'd0);
    chk({tag, "_req2"}, {31'd0, mem_if.req}, 32'd0);
    chk({tag, "_load_clr"}, o_load_data, 32'd0);
  endtask

  initial begin
    logic [2:0]  f3s [8];
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] a, d, r;
    logic        w;
    int          ak;
    f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2};

    i_rst = 1'b1;
    mem_if.ack = 1'b0; mem_if.rdata = 32'd0;
    drive(1'b0, 1'b1, 3'd2, 32'h100, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);
    chk("rst_misal", {31'd0, o_misaligned}, 32'd0);
    chk("rst_req", {31'd0, mem_if.req}, 32'd0);
    chk("rst_load", o_load_data, 32'd0);
    chk("rst_berr", {31'd0, o_bus_err}, 32'd0);
    chk("rst_addr", mem_if.addr, 32'd0);
    @(posedge clk); #1;
    i_ctrl = 32'd0;
    i_rst = 1'b0;

    run_op("lw",  1'b0, 1'b1, 3'd2, 32'h100, 32'd0, 2, 32'hDEADBEEF, 32'd0, 4'd0, 32'hDEADBEEF, 1'b0);
    run_op("lb",  1'b0, 1'b1, 3'd0, 32'h103, 32'd0, 1, 32'h80123456, 32'd0, 4'd0, 32'hFFFFFF80, 1'b0);
    run_op("lbu", 1'b0, 1'b1, 3'd4, 32'h103, 32'd0, 3, 32'h80123456, 32'd0, 4'd0, 32'h00000080, 1'b0);
    run_op("tmo", 1'b0, 1'b1, 3'd2, 32'h400, 32'd0, 0, 32'd0, 32'd0, 4'd0, 32'd0, 1'b1);
    run_op("ack_at_tmo", 1'b0, 1'b1, 3'd5, 32'h402, 32'd0, TMO, 32'h8001_7FFF, 32'd0, 4'd0,
           32'h0000_8001, 1'b0);
    run_op("sh",  1'b1, 1'b0, 3'd1, 32'h202, 32'h0000ABCD, 1, 32'hFFFF_FFFF, 32'hABCDABCD,
           4'b1100, 32'd0, 1'b0);
    run_op("sb_rw", 1'b1, 1'b1, 3'd0, 32'h205, 32'h0000_00A5, 2, 32'hFFFF_FFFF, 32'hA5A5A5A5,
           4'b0010, 32'd0, 1'b0);
    run_op("lw2", 1'b0, 1'b1, 3'd2, 32'h100, 32'd0, 1, 32'hDEADBEEF, 32'd0, 4'd0, 32'hDEADBEEF, 1'b0);
    run_fault("lw_mis", 1'b0, 1'b1, 3'd2, 32'h101);
    run_op("lh", 1'b0, 1'b1, 3'd1, 32'h102, 32'd0, 1, 32'h9ABC_0000, 32'd0, 4'd0, 32'hFFFF_9ABC, 1'b0);
    run_fault("f3_011", 1'b0, 1'b1, 3'd3, 32'h100);
    run_fault("sw_mis", 1'b1, 1'b0, 3'd2, 32'h102);
    run_fault("lbu_st", 1'b1, 1'b0, 3'd4, 32'h100);

    for (int i = 0; i < 8; i++) begin
      f3 = f3s[$urandom_range(0, 7)];
      w  = (f3 == 3'd4 || f3 == 3'd5) ? 1'b0 : 1'($urandom_range(0, 1));
      a  = $urandom;
      off = a[1:0];
      if (f3 == 3'd2) off = 2'd0;
      else if (f3[1:0] == 2'd1) off[0] = 1'b0;
      a[1:0] = off;
      d  = $urandom;
      r  = $urandom;
      ak = $urandom_range(1, TMO);
      run_op($sformatf("rnd%0d", i), w, ~w, f3, a, d, ak, r, m_wdata(f3, d), m_strb(f3, off),
             w ? 32'd0 : m_load(f3, off, r), 1'b0);
    end

    // Reset in the second ACCESS cycle, then a late ack
    run_op("pre_rst", 1'b0, 1'b1, 3'd2, 32'h104, 32'd0, 1, 32'h5555_AAAA, 32'd0, 4'd0,
           32'h5555_AAAA, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 3'd2, 32'h300, 32'hCAFE_F00D);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_acc1_req", {31'd0, mem_if.req}, 32'd1);
    @(posedge clk); #1;
    i_rst = 1'b1;
    @(negedge clk);
    chk("rst_acc2_stall", {31'd0, o_stall}, 32'd0);
    @(posedge clk); #1;
    i_rst = 1'b0;
    i_ctrl = 32'd0;
    mem_if.ack = 1'b1;
    mem_if.rdata = 32'h1234_5678;
    @(negedge clk);
    chk("post_rst_req", {31'd0, mem_if.req}, 32'd0);
    chk("post_rst_we", {31'd0, mem_if.we}, 32'd0);
    chk("post_rst_wdata", mem_if.wdata, 32'd0);
    chk("post_rst_wstrb", {28'd0, mem_if.wstrb}, 32'd0);
    chk("post_rst_load", o_load_data, 32'd0);
    chk("post_rst_stall", {31'd0, o_stall}, 32'd0);
    @(posedge clk); #1;
    mem_if.ack = 1'b0;
    @(negedge clk);
    chk("late_ack_load", o_load_data, 32'd0);
    chk("late_ack_req", {31'd0, mem_if.req}, 32'd0);
    chk("late_ack_berr", {31'd0, o_bus_err}, 32'd0);

    repeat (2) @(posedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit for the MEM stage of the pipelined CPU core. It consumes the EX/MEM pipeline register outputs (control word, ALU address, store data, instruction) and performs byte/half/word accesses on a ready/ack data-memory port. It holds the pipeline via `o_stall` (drives the EX/MEM and upstream enables low) while an access is outstanding. It delivers an extended load result for the MEM/WB register.

## Interface
- `DATA_WIDTH`, 32: data/address width; only 32 is supported.
- `TIMEOUT`, 255: maximum ACCESS cycles without `i_mem_ack` before an abort; range 1..255, 8-bit counter.
- `CTRL_RD_BIT`, 0: bit of `i_ctrl` meaning mem_read.
- `CTRL_WR_BIT`, 1: bit of `i_ctrl` meaning mem_write.

Ports:
- `clk` in 1: clock, all state on rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_ctrl` in 32: control word from EX/MEM.
- `i_alu` in 32: effective byte address.
- `i_data2` in 32: store data.
- `i_instr` in 32: instruction; funct3 = `i_instr[14:12]` selects size/sign.
- `o_stall` out 1: pipeline hold request (combinational).
- `o_mem_req` out 1: memory request, held until ack.
- `o_mem_we` out 1: 1 = write.
- `o_mem_addr` out 32: word-aligned address, `{alu[31:2],2'b00}`.
- `o_mem_wdata` out 32: lane-replicated store data.
- `o_mem_wstrb` out 4: byte enables.
- `i_mem_ack` in 1: memory accepted/completed the request; read data valid in the same cycle.
- `i_mem_rdata` in 32: read word.
- `o_load_data` out 32: extended load result (registered).
- `o_misaligned` out 1: one-cycle fault pulse, access suppressed.
- `o_bus_err` out 1: timeout abort indication.

## Operation
- A memory op is present when `i_ctrl[CTRL_WR_BIT]` or `i_ctrl[CTRL_RD_BIT]` is set. If both are set, the op is a store. Bubbles (both bits 0) pass with no action.
- Valid loads, by funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Valid stores, by funct3: 000 SB, 001 SH, 010 SW.
- Any other funct3 is a fault, treated as misaligned.
- A half access with `addr[0]=1` is misaligned. A word access with `addr[1:0]≠0` is misaligned.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, valid aligned op:
  - `o_stall=1`.
  - Register `o_mem_addr`, `o_mem_we`, `o_mem_wdata` and `o_mem_wstrb`.
  - Clear the timeout counter and go to ACCESS.
- IDLE, faulting op:
  - `o_misaligned=1`, `o_stall=0`, no request.
  - Stay in IDLE; `o_load_data` is cleared to 0.
- ACCESS:
  - `o_mem_req=1` and `o_stall=1`; request fields are held stable.
  - On `i_mem_ack`: capture the extended load (stores capture 0) into `o_load_data` and go to DONE.
  - On reaching `TIMEOUT` cycles without ack: `o_load_data=0`, set the bus-error flag and go to DONE.
- DONE:
  - `o_stall=0`, `o_mem_req=0`.
  - `o_bus_err` is high this cycle only if DONE was reached by timeout.
  - Go to IDLE unconditionally, without examining inputs. The EX/MEM register advances at the end of DONE.
- Store lanes:
  - SB: wdata `{4{d[7:0]}}`, wstrb `4'b0001<<addr[1:0]`.
  - SH: wdata `{2{d[15:0]}}`, wstrb `4'b0011<<addr[1:0]`.
  - SW: wdata `d`, wstrb `4'b1111`.
- Loads: shift `rdata` right by `8*addr[1:0]`, then sign- or zero-extend bit 7 or bit 15 per funct3. LW takes `rdata` unmodified.

## Timing
- Reset values: state IDLE, counter 0, and every output 0.
- `o_stall` and `o_misaligned` are forced to 0 while `i_rst` is high.
- Non-memory and faulting instructions take 1 cycle, with no stall.
- A memory op takes 2 + N cycles, where N is the number of ACCESS cycles up to and including the ack cycle (minimum N=1, so minimum 3 cycles).
- `o_load_data` is valid during DONE and the following cycles until the next capture. MEM/WB samples it at the end of DONE.
- `i_mem_ack` outside ACCESS is ignored.
- Ack arriving in the same cycle as the counter reaching `TIMEOUT`: the ack wins and there is no bus error.
- Reset during ACCESS: the next cycle is IDLE with `o_mem_req=0`. The abandoned request needs no completion; a late ack is ignored.
- Inputs are assumed stable while `o_stall=1`; the block does not re-sample them after IDLE.

## Test plan
- LW, addr 0x100, ack after 2 ACCESS cycles, rdata 0xDEADBEEF:
  - `o_mem_addr`=0x100, stall asserted for 3 cycles.
  - DONE shows `o_load_data`=0xDEADBEEF.
- LB at addr 0x103, and LBU at addr 0x103, each with rdata 0x80123456:
  - LB gives `o_load_data`=0xFFFFFF80.
  - LBU gives `o_load_data`=0x00000080.
- SH, addr 0x202, data 0x0000ABCD:
  - `o_mem_we`=1, `o_mem_wstrb`=4'b1100, `o_mem_wdata`=0xABCDABCD.
- LW at addr 0x101, and funct3=011 with mem_read:
  - `o_misaligned` pulses for 1 cycle, no `o_mem_req`, stall stays 0, `o_load_data`=0.
- TIMEOUT=4, no ack:
  - `o_mem_req` high for exactly 4 cycles.
  - DONE shows `o_bus_err`=1 and `o_load_data`=0, and stall drops.
- `i_rst` asserted in the 2nd ACCESS cycle, followed by a late ack:
  - Next cycle is IDLE with all outputs 0, and the late ack has no effect.
